perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter WIDTH, default 32, is the bit width of each counter.
REQ-002 Parameter CHANNELS, default 4, is the number of independent counters, legal range 2..16.
REQ-003 Parameter SATURATE, default 0, selects overflow mode: 0 = wrap, 1 = saturate.
REQ-004 Port clk, input, 1, is the clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1, is a synchronous, active-high reset.
REQ-006 Port inc, input, CHANNELS, is the per-channel count request (bit i = channel i).
REQ-007 Port dir, input, CHANNELS, is the per-channel direction: 0 = up, 1 = down.
REQ-008 Port clr, input, CHANNELS, is the per-channel counter clear.
REQ-009 Ports wr_en (1), wr_sel ($clog2(CHANNELS)) and wr_data (WIDTH), inputs, load wr_data into channel wr_sel.
REQ-010 Ports rd_en (1) and rd_sel ($clog2(CHANNELS)), inputs, request a read of channel rd_sel.
REQ-011 Port rd_data, output, WIDTH, is the registered read result.
REQ-012 Port rd_valid, output, 1, marks rd_data valid for one cycle.
REQ-013 Port ovf, output, CHANNELS, holds the sticky per-channel over/underflow flags.
REQ-014 Port ovf_clr, input, CHANNELS, is a write-1-to-clear for ovf.

Function
REQ-015 Per-channel update priority SHALL be: clr, then load (wr_en with wr_sel == i), then inc; only the highest-priority action SHALL take effect.
REQ-016 inc[i]=1, dir[i]=0: cnt[i] SHALL become cnt[i]+1 on the next edge; inc[i]=0 SHALL hold the value.
REQ-017 inc[i]=1, dir[i]=1: cnt[i] SHALL become cnt[i]-1 on the next edge.
REQ-018 Up-count from all-ones SHALL yield 0 when SATURATE=0 and all-ones when SATURATE=1; either way ovf[i] SHALL set.
REQ-019 Down-count from 0 SHALL yield all-ones when SATURATE=0 and 0 when SATURATE=1; either way ovf[i] SHALL set.
REQ-020 Clear or load SHALL NOT set or clear ovf[i].
REQ-021 ovf[i] SHALL stay set until ovf_clr[i]=1 or reset; an ovf_clr and a new overflow in the same cycle SHALL leave ovf[i] set.
REQ-022 rd_en=1 SHALL return the value of cnt[rd_sel] before that edge's update on rd_data one cycle later, with rd_valid=1 for exactly that cycle.
REQ-023 rd_data SHALL hold its last value while rd_valid=0.
REQ-024 All channels SHALL update independently and concurrently in the same cycle.
REQ-025 wr_sel or rd_sel >= CHANNELS SHALL be ignored: no load; on a read, rd_valid=1 and rd_data=0.

Reset
REQ-026 While reset=1 at an edge, every counter, ovf, rd_data and rd_valid SHALL become 0; reset SHALL override all other inputs.
REQ-027 A read or overflow in flight when reset asserts SHALL be discarded: no rd_valid pulse and no ovf after reset.

Configuration
REQ-028 Macro PERF_COUNTER_IRQ_EN, when defined, SHALL add an input irq_mask (CHANNELS) and an output irq (1, registered).
REQ-029 With the macro defined, irq SHALL equal the OR of (ovf & irq_mask) from the previous cycle and SHALL reset to 0.
REQ-030 Without the macro, the irq_mask and irq ports and their logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8, CHANNELS=4)
REQ-031 Reset, then inc=4'b0001 for 5 cycles, then read channel 0 -> rd_data=5 with rd_valid high for 1 cycle; all ovf=0.
REQ-032 SATURATE=0: load ch1=8'hFE, then inc ch1 for 3 cycles -> value 8'h01, ovf[1]=1; pulse ovf_clr[1] -> ovf[1]=0.
REQ-033 SATURATE=1: load ch2=8'h01, dir[2]=1, inc for 3 cycles -> value 0, ovf[2]=1.
REQ-034 In one cycle: clr[3]=1, wr_en to ch3 and inc[3]=1 -> ch3=0; then wr_en with inc -> ch3=wr_data.
REQ-035 Overflow on ch0 while ovf_clr[0]=1 in the same cycle -> ovf[0]=1; with PERF_COUNTER_IRQ_EN and irq_mask[0]=1 -> irq=1 one cycle later.
REQ-036 Assert reset in the same cycle as rd_en -> next cycle rd_valid=0 and all counters, ovf and rd_data=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of independent up/down event counters with load, clear, read-back and sticky overflow
// Optional feature: define PERF_COUNTER_IRQ_EN to add irq_mask input and registered irq output.
module perf_counter_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter bit SATURATE = 1'b0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] inc,
  input  logic [CHANNELS-1:0] dir,
  input  logic [CHANNELS-1:0] clr,
  input  logic                wr_en,
  input  logic [SELW-1:0]     wr_sel,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [SELW-1:0]     rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] ovf,
  input  logic [CHANNELS-1:0] ovf_clr
`ifdef PERF_COUNTER_IRQ_EN
  ,
  input  logic [CHANNELS-1:0] irq_mask,
  output logic                irq
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d, ovf_set;
  logic [CHANNELS-1:0] wr_hit;
  logic [WIDTH-1:0]    rd_data_q, rd_mux;
  logic                rd_valid_q;

  // Out-of-range wr_sel shifts the one-hot bit off the top, so nothing loads.
  assign wr_hit = wr_en ? (CHANNELS'(1) << wr_sel) : '0;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (wr_hit[i]) begin
        cnt_d[i] = wr_data;
      end else if (inc[i]) begin
        if (!dir[i]) begin
          if (cnt_q[i] == ALL_ONES) begin
            ovf_set[i] = 1'b1;
            cnt_d[i]   = SATURATE ? ALL_ONES : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            ovf_set[i] = 1'b1;
            cnt_d[i]   = SATURATE ? '0 : ALL_ONES;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
      end
    end
    // A fresh overflow wins over a same-cycle write-1-to-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SELW'(i)) rd_mux = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;

`ifdef PERF_COUNTER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(ovf_q & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed bench for perf_counter_bank, wrap and saturate instances side by side
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] inc, dir, clr, ovf_clr;
  logic       wr_en, rd_en;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] wr_data;
  logic [7:0] rd_data_w, rd_data_s;
  logic       rd_valid_w, rd_valid_s;
  logic [3:0] ovf_w, ovf_s;
`ifdef PERF_COUNTER_IRQ_EN
  logic [3:0] irq_mask;
  logic       irq_w, irq_s;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .inc(inc), .dir(dir), .clr(clr),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
    .ovf(ovf_w), .ovf_clr(ovf_clr)
`ifdef PERF_COUNTER_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w)
`endif
  );

  perf_counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .inc(inc), .dir(dir), .clr(clr),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .ovf(ovf_s), .ovf_clr(ovf_clr)
`ifdef PERF_COUNTER_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] ch);
    rd_en  = 1'b1;
    rd_sel = ch;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] ch, input logic [7:0] val);
    wr_en   = 1'b1;
    wr_sel  = ch;
    wr_data = val;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inc = '0; dir = '0; clr = '0; ovf_clr = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_en = 1'b0; rd_sel = '0;
`ifdef PERF_COUNTER_IRQ_EN
    irq_mask = 4'b0001;
`endif
    tick(); tick();
    reset = 1'b0;
    check("rst_rd_valid", {31'd0, rd_valid_w}, 32'd0);
    check("rst_rd_data",  {24'd0, rd_data_w},  32'd0);
    check("rst_ovf_w",    {28'd0, ovf_w},      32'd0);
    check("rst_ovf_s",    {28'd0, ovf_s},      32'd0);
`ifdef PERF_COUNTER_IRQ_EN
    check("rst_irq", {31'd0, irq_w}, 32'd0);
`endif

    // five up-counts on channel 0
    inc = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    inc = '0;
    do_read(2'd0);
    check("cnt5_data_w",  {24'd0, rd_data_w},  32'd5);
    check("cnt5_data_s",  {24'd0, rd_data_s},  32'd5);
    check("cnt5_valid",   {31'd0, rd_valid_w}, 32'd1);
    check("cnt5_ovf",     {28'd0, ovf_w},      32'd0);
    tick();
    check("cnt5_valid_drop", {31'd0, rd_valid_w}, 32'd0);
    check("cnt5_data_hold",  {24'd0, rd_data_w},  32'd5);

    // channel 1: FE + 3 up-counts
    do_load(2'd1, 8'hFE);
    inc = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    inc = '0;
    do_read(2'd1);
    check("wrap_up_data", {24'd0, rd_data_w}, 32'h01);
    check("sat_up_data",  {24'd0, rd_data_s}, 32'hFF);
    check("wrap_up_ovf",  {28'd0, ovf_w},     32'b0010);
    check("sat_up_ovf",   {28'd0, ovf_s},     32'b0010);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    check("ovf_clr_w", {28'd0, ovf_w}, 32'd0);
    check("ovf_clr_s", {28'd0, ovf_s}, 32'd0);

    // channel 2: 01 + 3 down-counts
    do_load(2'd2, 8'h01);
    inc = 4'b0100; dir = 4'b0100;
    for (int k = 0; k < 3; k++) tick();
    inc = '0; dir = '0;
    do_read(2'd2);
    check("sat_dn_data",  {24'd0, rd_data_s}, 32'h00);
    check("wrap_dn_data", {24'd0, rd_data_w}, 32'hFE);
    check("sat_dn_ovf",   {28'd0, ovf_s},     32'b0100);
    check("wrap_dn_ovf",  {28'd0, ovf_w},     32'b0100);

    // channel 3 priority: clr beats load beats inc
    clr = 4'b1000; inc = 4'b1000; wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'h55;
    tick();
    clr = '0;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0; inc = '0;
    check("load_no_ovf", {28'd0, ovf_w}, 32'b0100);
    do_read(2'd3);
    check("prio_load_data", {24'd0, rd_data_w}, 32'h77);
    // rebuild clr case with read of the cleared value
    clr = 4'b1000; inc = 4'b1000; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    clr = '0; inc = '0; wr_en = 1'b0;
    do_read(2'd3);
    check("prio_clr_data", {24'd0, rd_data_w}, 32'h00);
    check("clr_no_ovf",    {28'd0, ovf_s},     32'b0100);
    do_load(2'd3, 8'h77);

    // channel 0 overflow racing its own ovf_clr
    do_load(2'd0, 8'hFF);
    inc = 4'b0001; ovf_clr = 4'b0001;
    tick();
    inc = '0; ovf_clr = '0;
    check("race_ovf_w", {28'd0, ovf_w}, 32'b0101);
    check("race_ovf_s", {28'd0, ovf_s}, 32'b0101);
`ifdef PERF_COUNTER_IRQ_EN
    check("irq_not_yet", {31'd0, irq_w}, 32'd0);
    tick();
    check("irq_set_w", {31'd0, irq_w}, 32'd1);
    check("irq_set_s", {31'd0, irq_s}, 32'd1);
`endif

    // all four channels count up together
    inc = 4'b1111;
    tick();
    inc = '0;
    do_read(2'd1);
    check("conc_ch1_w", {24'd0, rd_data_w}, 32'h02);
    check("conc_ch1_s", {24'd0, rd_data_s}, 32'hFF);
    do_read(2'd2);
    check("conc_ch2_w", {24'd0, rd_data_w}, 32'hFF);
    check("conc_ch2_s", {24'd0, rd_data_s}, 32'h01);
    do_read(2'd3);
    check("conc_ch3_w", {24'd0, rd_data_w}, 32'h78);
    check("conc_ovf_s", {28'd0, ovf_s},     32'b0111);

    // reset together with a read request
    rd_en = 1'b1; rd_sel = 2'd3; reset = 1'b1;
    tick();
    rd_en = 1'b0; reset = 1'b0;
    check("rst_rd_valid_w", {31'd0, rd_valid_w}, 32'd0);
    check("rst_rd_data_w",  {24'd0, rd_data_w},  32'd0);
    check("rst2_ovf_w",     {28'd0, ovf_w},      32'd0);
    check("rst2_ovf_s",     {28'd0, ovf_s},      32'd0);
    tick();
    check("rst_no_late_valid", {31'd0, rd_valid_s}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      do_read(2'(c));
      check($sformatf("rst_cnt%0d_w", c), {24'd0, rd_data_w}, 32'd0);
      check($sformatf("rst_cnt%0d_s", c), {24'd0, rd_data_s}, 32'd0);
    end
`ifdef PERF_COUNTER_IRQ_EN
    check("rst2_irq", {31'd0, irq_w}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
